dmem_responder: RTL and testbench

Data-memory responder for the MIPS pipeline. Services the memory request carried out of the EX/MEM pipeline register (read size, write enable, address, store data) and returns load data for the MEM/WB register. Models a fixed-latency memory: `stall_OUT` freezes the upstream pipeline registers while a request is pending. Word array with word/half/byte loads, word stores and misalignment detection.

---
 rtl/dmem_responder.sv | 123 ++++++++++++
 tb/tb_dmem_responder.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Fixed-latency data memory for the MEM stage: word array, sized sign-extended loads, word stores.
// Build with DMEM_MISALIGN_TRAP_EN defined to flag and suppress misaligned word/half accesses.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  memReadFLAG_IN,
  input  logic        memWriteFLAG_IN,
  input  logic [31:0] ALU_RESULT_IN,
  input  logic [31:0] READ_DATA_2_IN,
  output logic [31:0] dataMemoryOut_OUT,
  output logic        stall_OUT,
  output logic        misaligned_OUT
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  logic [0:0]  state;
  logic [3:0]  cnt;
  logic [31:0] mem [DEPTH_WORDS];

  logic          req;
  logic          is_store;
  logic          is_load;
  logic          done;
  logic          stall;
  logic          mis;
  logic [AW-1:0] idx;
  logic [31:0]   word;
  logic [31:0]   ext;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic          unused_hi;

  assign req      = memWriteFLAG_IN | (|memReadFLAG_IN);
  assign is_store = memWriteFLAG_IN;
  assign is_load  = ~memWriteFLAG_IN & (|memReadFLAG_IN);
  assign idx      = ALU_RESULT_IN[AW+1:2];
  assign word     = mem[idx];

  // Address bits above the array wrap around.
  assign unused_hi = ^ALU_RESULT_IN[31:AW+2];

  always_comb begin
    done  = 1'b0;
    stall = 1'b0;
    if (!rst && req) begin
      if (state == S_IDLE) begin
        if (WS == 4'd0) done = 1'b1;
        else            stall = 1'b1;
      end else if (cnt >= WS) begin
        done = 1'b1;
      end else begin
        stall = 1'b1;
      end
    end
  end

  always_comb begin
    mis = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    if (is_store || memReadFLAG_IN == 2'b01)
      mis = |ALU_RESULT_IN[1:0];
    else if (memReadFLAG_IN == 2'b10)
      mis = ALU_RESULT_IN[0];
`endif
  end

  assign byte_sel = word[{ALU_RESULT_IN[1:0], 3'b000} +: 8];
  assign half_sel = ALU_RESULT_IN[1] ? word[31:16] : word[15:0];

  always_comb begin
    ext = 32'd0;
    unique case (memReadFLAG_IN)
      2'b01:   ext = word;
      2'b10:   ext = {{16{half_sel[15]}}, half_sel};
      2'b11:   ext = {{24{byte_sel[7]}}, byte_sel};
      default: ext = 32'd0;
    endcase
  end

  assign dataMemoryOut_OUT = (done && is_load && !mis) ? ext : 32'd0;
  assign stall_OUT         = stall;
  assign misaligned_OUT    = done & mis;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req && WS != 4'd0) begin
            state <= S_WAIT;
            cnt   <= 4'd1;
          end
        end
        default: begin
          // A dropped request is a pipeline flush.
          if (!req || cnt >= WS) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
      endcase
    end
  end

  // Array has no reset; done already excludes reset cycles.
  always_ff @(posedge clk) begin
    if (done && is_store && !mis)
      mem[idx] <= READ_DATA_2_IN;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: table-driven accesses at WAIT_STATES=2,
// reset corner cases, and a zero-wait alternating store/load stream.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  rd, rd0;
  logic        we, we0;
  logic [31:0] addr, wd, addr0, wd0;
  logic [31:0] dout, dout0;
  logic        stall, stall0, mis, mis0;

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(2)) dut (
    .clk(clk), .rst(rst),
    .memReadFLAG_IN(rd), .memWriteFLAG_IN(we),
    .ALU_RESULT_IN(addr), .READ_DATA_2_IN(wd),
    .dataMemoryOut_OUT(dout), .stall_OUT(stall),
    .misaligned_OUT(mis)
  );

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst),
    .memReadFLAG_IN(rd0), .memWriteFLAG_IN(we0),
    .ALU_RESULT_IN(addr0), .READ_DATA_2_IN(wd0),
    .dataMemoryOut_OUT(dout0), .stall_OUT(stall0),
    .misaligned_OUT(mis0)
  );

`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [1:0]  rd;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    logic        mis;
  } vec_t;

  vec_t        vecs[$];
  logic [32:0] sb[$];
  int          tests = 0;
  int          fails = 0;

  function automatic vec_t mk(string n, logic [1:0] r, logic w,
                              logic [31:0] a, logic [31:0] d,
                              logic [31:0] e, logic m);
    vec_t v;
    v.name = n; v.rd = r; v.we = w; v.addr = a;
    v.wdata = d; v.exp = e; v.mis = m;
    return v;
  endfunction

  task automatic check(string n, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // Called just after a posedge; returns just after the completion posedge.
  task automatic access(input vec_t v);
    int n;
    logic [32:0] e;
    rd = v.rd; we = v.we; addr = v.addr; wd = v.wdata;
    sb.push_back({v.mis, v.exp});
    n = 0;
    forever begin
      @(negedge clk);
      if (stall !== 1'b1 || n > 20) break;
      n++;
    end
    check({v.name, " stalls"}, 32'(n), 32'd2);
    e = sb.pop_front();
    check({v.name, " data"}, dout, e[31:0]);
    check({v.name, " mis"}, 32'(mis), 32'(e[32]));
    @(posedge clk); #1;
    rd = 2'b00; we = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    logic [32:0] e;
    rst = 1'b1;
    rd = 0; we = 0; addr = 0; wd = 0;
    rd0 = 0; we0 = 0; addr0 = 0; wd0 = 0;

    vecs.push_back(mk("sw10",  2'b00, 1, 32'h10,  32'hDEADBEEF, 0, 0));
    vecs.push_back(mk("lw10",  2'b01, 0, 32'h10,  0, 32'hDEADBEEF, 0));
    vecs.push_back(mk("sw20",  2'b00, 1, 32'h20,  32'h80017F80, 0, 0));
    vecs.push_back(mk("lb20",  2'b11, 0, 32'h20,  0, 32'hFFFFFF80, 0));
    vecs.push_back(mk("lb21",  2'b11, 0, 32'h21,  0, 32'h0000007F, 0));
    vecs.push_back(mk("lb22",  2'b11, 0, 32'h22,  0, 32'h00000001, 0));
    vecs.push_back(mk("lb23",  2'b11, 0, 32'h23,  0, 32'hFFFFFF80, 0));
    vecs.push_back(mk("lh22",  2'b10, 0, 32'h22,  0, 32'hFFFF8001, 0));
    vecs.push_back(mk("lh20",  2'b10, 0, 32'h20,  0, 32'h00007F80, 0));
    vecs.push_back(mk("sw04",  2'b00, 1, 32'h04,  32'h12345678, 0, 0));
    vecs.push_back(mk("lw404", 2'b01, 0, 32'h404, 0, 32'h12345678, 0));
    vecs.push_back(mk("sw30",  2'b00, 1, 32'h30,  32'hCAFEF00D, 0, 0));
    vecs.push_back(mk("sw40",  2'b00, 1, 32'h40,  32'hA5A5A5A5, 0, 0));
    vecs.push_back(mk("sw41",  2'b00, 1, 32'h41,  32'h11111111, 0, TRAP));
    vecs.push_back(mk("lw40",  2'b01, 0, 32'h40,  0,
                      TRAP ? 32'hA5A5A5A5 : 32'h11111111, 0));
    vecs.push_back(mk("lw42",  2'b01, 0, 32'h42,  0,
                      TRAP ? 32'h0 : (TRAP ? 32'h0 : 32'h11111111), TRAP));
    vecs.push_back(mk("rdwr50", 2'b01, 1, 32'h50, 32'h00000055, 0, 0));
    vecs.push_back(mk("lw50",  2'b01, 0, 32'h50,  0, 32'h00000055, 0));

    // Outputs held quiet while reset is high, even with a request present.
    repeat (2) @(posedge clk);
    #1;
    rd = 2'b01; rd0 = 2'b01; addr = 32'h10; addr0 = 32'h10;
    @(negedge clk);
    check("rst stall",  32'(stall), 32'd0);
    check("rst dout",   dout, 32'd0);
    check("rst mis",    32'(mis), 32'd0);
    check("rst dout0",  dout0, 32'd0);
    check("rst stall0", 32'(stall0), 32'd0);
    @(posedge clk); #1;
    rd = 2'b00; rd0 = 2'b00; rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++)
      access(vecs[i]);

    // Store to 0x30 aborted by reset on its second stall cycle.
    we = 1'b1; addr = 32'h30; wd = 32'h0BAD0BAD;
    @(negedge clk);
    check("abort stall1", 32'(stall), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("abort stall rst", 32'(stall), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; we = 1'b0;
    @(negedge clk);
    check("abort stall after", 32'(stall), 32'd0);
    @(posedge clk); #1;
    access(mk("lw30", 2'b01, 0, 32'h30, 0, 32'hCAFEF00D, 0));

    // Zero wait states: store then load every cycle, never stalling.
    for (int i = 0; i < 6; i++) begin
      we0 = 1'b1; rd0 = 2'b00;
      addr0 = 32'h80 + 32'(4 * (i % 3));
      wd0 = $urandom;
      d = wd0;
      @(negedge clk);
      check("ws0 st stall", 32'(stall0), 32'd0);
      check("ws0 st dout", dout0, 32'd0);
      @(posedge clk); #1;
      we0 = 1'b0; rd0 = 2'b01;
      sb.push_back({1'b0, d});
      @(negedge clk);
      e = sb.pop_front();
      check("ws0 ld stall", 32'(stall0), 32'd0);
      check("ws0 ld data", dout0, e[31:0]);
      @(posedge clk); #1;
    end
    rd0 = 2'b00;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
